// File: rtl/store_addr_pkg.sv
// rtl/store_addr_pkg.sv - shared defaults and FSM state encoding for the store_addr read path
package store_addr_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_LEN_W     = 8;
    localparam int DEF_BURST_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ISSUE   = 2'd3
    } rd_state_e;

endpackage

// File: rtl/store_addr_credit_cnt.sv
// rtl/store_addr_credit_cnt.sv - saturating outstanding-burst counter with sticky underflow flag
module store_addr_credit_cnt #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             below_limit,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // count accepted bursts up and completions down; a completion with nothing
    // outstanding leaves the count at zero and latches the error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (dec && (count == '0)) begin
                underflow <= 1'b1;
            end
            case ({inc, dec})
                2'b10: if (count != MAX_CNT) count <= count + 1'b1;
                2'b01: if (count != '0)      count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign below_limit = (count < MAX_CNT);

endmodule

// File: rtl/store_addr_reader.sv
// rtl/store_addr_reader.sv - pops frame-buffer addresses and issues credit-limited read-burst commands
module store_addr_reader
    import store_addr_pkg::*;
#(
    parameter int          ADDR_W          = DEF_ADDR_W,
    parameter int          LEN_W           = DEF_LEN_W,
    parameter int          BURST_LEN       = DEF_BURST_LEN,
    parameter int unsigned ADDR_OFFSET     = 0,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          CNT_W           = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    output logic              fifo_rd_en,
    input  logic [ADDR_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              rsp_done,
    output logic [CNT_W-1:0]  outstanding,
    output logic              busy,
    output logic              err_underflow,
    output logic [31:0]       cmd_count
);

    rd_state_e state_q;
    rd_state_e state_d;
    logic      accept;
    logic      below_limit;

    assign accept     = cmd_valid & cmd_ready;
    assign fifo_rd_en = (state_q == ST_POP);
    assign cmd_len    = LEN_W'(BURST_LEN);
    assign busy       = (state_q != ST_IDLE) || (outstanding != '0);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: a pop starts only from IDLE; once started the address always reaches ISSUE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && !flush && !fifo_rd_empty && below_limit) begin
                    state_d = ST_POP;
                end
            end
            ST_POP:     state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // command register: load the offset address when FIFO data lands, hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_count <= '0;
        end else begin
            if (state_q == ST_CAPTURE) begin
                cmd_addr  <= fifo_rd_data + ADDR_W'(ADDR_OFFSET);
                cmd_valid <= 1'b1;
            end else if (accept) begin
                cmd_valid <= 1'b0;
            end
            if (accept) begin
                cmd_count <= cmd_count + 32'd1;
            end
        end
    end

    store_addr_credit_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (accept),
        .dec         (rsp_done),
        .count       (outstanding),
        .below_limit (below_limit),
        .underflow   (err_underflow)
    );

endmodule

// File: tb/tb_store_addr_reader.sv
// tb/tb_store_addr_reader.sv - randomized and directed self-checking bench for store_addr_reader
module tb_store_addr_reader;

    localparam int ADDR_W    = 10;
    localparam int LEN_W     = 8;
    localparam int BURST_LEN = 16;
    localparam int OFFS      = 2;
    localparam int MAXO      = 4;
    localparam int CNT_W     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              flush;
    logic              fifo_rd_en;
    logic [ADDR_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              rsp_done;
    logic [CNT_W-1:0]  outstanding;
    logic              busy;
    logic              err_underflow;
    logic [31:0]       cmd_count;

    always #5 clk = ~clk;

    store_addr_reader #(
        .ADDR_W          (ADDR_W),
        .LEN_W           (LEN_W),
        .BURST_LEN       (BURST_LEN),
        .ADDR_OFFSET     (OFFS),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .flush         (flush),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .rsp_done      (rsp_done),
        .outstanding   (outstanding),
        .busy          (busy),
        .err_underflow (err_underflow),
        .cmd_count     (cmd_count)
    );

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    logic [ADDR_W-1:0] fq[$];
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] acc_addr[$];
    int                acc_cyc[$];
    int                m_out;
    int                m_cnt;
    bit                m_err;
    bit                inflight;
    bit                pop_pending;
    logic [ADDR_W-1:0] pop_val;
    int                acc;
    int                pops;
    int                last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        exp_q.delete();
        acc_addr.delete();
        acc_cyc.delete();
        m_out       = 0;
        m_cnt       = 0;
        m_err       = 1'b0;
        inflight    = 1'b0;
        pop_pending = 1'b0;
        acc         = 0;
        pops        = 0;
        last_acc    = -100;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rd_en"},     32'(fifo_rd_en), 0);
        check({pfx, "_valid"},     32'(cmd_valid), 0);
        check({pfx, "_addr"},      32'(cmd_addr), 0);
        check({pfx, "_len"},       32'(cmd_len), BURST_LEN);
        check({pfx, "_outst"},     32'(outstanding), 0);
        check({pfx, "_busy"},      32'(busy), 0);
        check({pfx, "_underflow"}, 32'(err_underflow), 0);
        check({pfx, "_count"},     cmd_count, 0);
    endtask

    // called at a falling edge with inputs for the next rising edge already driven
    task automatic step();
        bit                start_ok;
        bit                expect_pop;
        bit                accept;
        bit                hold;
        bit                exp_busy;
        logic [ADDR_W-1:0] hold_addr;
        start_ok   = enable && !flush && !fifo_rd_empty && (m_out < MAXO);
        expect_pop = !inflight && start_ok;
        accept     = cmd_valid && cmd_ready;
        if (accept) begin
            if (exp_q.size() == 0) begin
                check("cmd_unexpected", 1, 0);
            end else begin
                check("cmd_addr", 32'(cmd_addr), 32'(exp_q.pop_front()));
            end
            check("cmd_len", 32'(cmd_len), BURST_LEN);
            check("cmd_spacing_min", 32'(cyc - last_acc >= 4), 1);
            acc_addr.push_back(cmd_addr);
            acc_cyc.push_back(cyc);
            last_acc = cyc;
            m_cnt++;
            acc++;
            inflight = 1'b0;
        end
        hold      = cmd_valid && !cmd_ready;
        hold_addr = cmd_addr;
        if (rsp_done && m_out == 0) m_err = 1'b1;
        if (accept && !rsp_done) m_out++;
        else if (!accept && rsp_done && m_out > 0) m_out--;

        @(posedge clk);
        #1;
        if (pop_pending) begin
            fifo_rd_data = pop_val;
            pop_pending  = 1'b0;
        end else begin
            fifo_rd_data = ADDR_W'($urandom);
        end
        fifo_rd_empty = (fq.size() == 0);
        cyc++;
        @(negedge clk);

        exp_busy = (m_out != 0) || inflight || fifo_rd_en;
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(expect_pop));
        check("outstanding", 32'(outstanding), 32'(m_out));
        check("cmd_count", cmd_count, 32'(m_cnt));
        check("err_underflow", 32'(err_underflow), 32'(m_err));
        check("busy", 32'(busy), 32'(exp_busy));
        if (hold) begin
            check("hold_valid", 32'(cmd_valid), 1);
            check("hold_addr", 32'(cmd_addr), 32'(hold_addr));
        end
        if (fifo_rd_en) begin
            if (fq.size() == 0) begin
                check("pop_empty", 1, 0);
            end else begin
                pop_val     = fq.pop_front();
                pop_pending = 1'b1;
                exp_q.push_back(pop_val + ADDR_W'(OFFS));
            end
            pops++;
            inflight = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        enable        = 1'b0;
        flush         = 1'b0;
        cmd_ready     = 1'b0;
        rsp_done      = 1'b0;
        fifo_rd_empty = 1'b1;
        fifo_rd_data  = '0;
        #1;
        check_reset_values("reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_rsp();
        rsp_done = 1'b1;
        step();
        rsp_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !cmd_valid; i++) step();
        check(tag, 32'(cmd_valid), 1);
    endtask

    initial begin
        int acc_before;
        int pops_before;
        logic [ADDR_W-1:0] exp_addrs[3];
        exp_addrs[0] = 10'h012;
        exp_addrs[1] = 10'h022;
        exp_addrs[2] = 10'h001;

        rst_n = 1'b1; enable = 1'b0; flush = 1'b0; cmd_ready = 1'b0;
        rsp_done = 1'b0; fifo_rd_empty = 1'b1; fifo_rd_data = '0;
        model_reset();
        apply_reset();

        // three addresses with offset, one including address wrap
        fq.push_back(10'h010); fq.push_back(10'h020); fq.push_back(10'h3FF);
        enable = 1'b1; cmd_ready = 1'b1;
        for (int i = 0; i < 30 && acc < 3; i++) step();
        repeat (3) step();
        check("t1_acc", 32'(acc), 3);
        for (int i = 0; i < 3 && i < acc_addr.size(); i++) check("t1_addr", 32'(acc_addr[i]), 32'(exp_addrs[i]));
        for (int i = 1; i < acc_cyc.size(); i++) check("t1_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 4);
        check("t1_count", cmd_count, 3);
        check("t1_outst", 32'(outstanding), 3);

        // credit limit: six queued, only four may issue until a completion
        apply_reset();
        for (int i = 0; i < 6; i++) fq.push_back(ADDR_W'($urandom));
        enable = 1'b1; cmd_ready = 1'b1;
        repeat (40) step();
        check("t2_acc", 32'(acc), 4);
        check("t2_pops", 32'(pops), 4);
        check("t2_outst", 32'(outstanding), MAXO);
        pulse_rsp();
        repeat (20) step();
        check("t2_acc_after_rsp", 32'(acc), 5);
        check("t2_pops_after_rsp", 32'(pops), 5);

        // backpressure: ready low for ten cycles, accepted on the eleventh
        cmd_ready = 1'b0;
        pulse_rsp();
        wait_valid("t3_wait_valid");
        acc_before = acc;
        for (int i = 0; i < 10; i++) begin
            check("t3_valid_held", 32'(cmd_valid), 1);
            step();
        end
        cmd_ready = 1'b1;
        step();
        check("t3_accept", 32'(acc), 32'(acc_before + 1));
        check("t3_outst", 32'(outstanding), MAXO);

        // accept and completion in the same cycle with two outstanding
        pulse_rsp();
        pulse_rsp();
        cmd_ready = 1'b0;
        fq.push_back(ADDR_W'($urandom));
        wait_valid("t4_wait_valid");
        check("t4_outst_before", 32'(outstanding), 2);
        cmd_ready = 1'b1;
        rsp_done  = 1'b1;
        step();
        rsp_done  = 1'b0;
        check("t4_outst_same", 32'(outstanding), 2);
        check("t4_count", cmd_count, 7);

        // completion with nothing outstanding
        pulse_rsp();
        pulse_rsp();
        check("t5_no_err_yet", 32'(err_underflow), 0);
        pulse_rsp();
        check("t5_err_set", 32'(err_underflow), 1);
        check("t5_outst_zero", 32'(outstanding), 0);
        repeat (5) step();
        check("t5_err_sticky", 32'(err_underflow), 1);

        // flush raised during CAPTURE, then async reset during a later ISSUE
        apply_reset();
        for (int i = 0; i < 3; i++) fq.push_back(ADDR_W'($urandom));
        enable = 1'b1; cmd_ready = 1'b1;
        for (int i = 0; i < 10 && !fifo_rd_en; i++) step();
        check("t6_first_pop", 32'(fifo_rd_en), 1);
        step();
        flush = 1'b1;
        repeat (20) step();
        check("t6_acc", 32'(acc), 1);
        check("t6_pops", 32'(pops), 1);
        flush = 1'b0; cmd_ready = 1'b0;
        wait_valid("t6_wait_valid");
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 8) fq.push_back(ADDR_W'($urandom));
            enable    = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            cmd_ready = ($urandom_range(0, 2) != 0);
            rsp_done  = (m_out > 0) && ($urandom_range(0, 3) == 0);
            step();
        end
        enable = 1'b1; flush = 1'b0; cmd_ready = 1'b1;
        for (int i = 0; i < 300 && (fq.size() != 0 || inflight || pop_pending); i++) begin
            rsp_done = (m_out > 0) && (i % 2 == 0);
            step();
        end
        rsp_done = 1'b0;
        step();
        check("drain_fifo_empty", 32'(fq.size()), 0);
        check("drain_idle", 32'(inflight), 0);
        check("drain_count", cmd_count, 32'(m_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_addr_reader.md
Name: store_addr_reader

Overview:
- Consumer on the read side of the store_addr FIFO (first-word-fall-through off, output register off: data arrives 1 cycle after rd_en).
- Pops stored frame-buffer addresses one at a time, adds a fixed base offset and issues one memory read-burst command per address over a valid/ready handshake.
- Tracks outstanding bursts against a credit limit, using one completion pulse per burst.
- Sits between the address FIFO and the DDR read-command arbiter in the video read path.

Parameters:
- ADDR_W, 10, width of the FIFO read data and of cmd_addr.
- LEN_W, 8, width of cmd_len.
- BURST_LEN, 16, constant burst length driven on cmd_len; legal range 1 to 2^LEN_W-1.
- ADDR_OFFSET, 0, constant added to every popped address, modulo 2^ADDR_W.
- MAX_OUTSTANDING, 4, maximum number of accepted but not completed bursts; legal range 1 to 15.
- CNT_W, 4, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; when 0 no new pops start, and in-progress pops and issues complete normally.
- flush  in  1  level; blocks new pops; see Behaviour.
- fifo_rd_en  out  1  FIFO read enable; asserted for exactly 1 cycle per pop.
- fifo_rd_data  in  ADDR_W  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- cmd_valid  out  1  read command valid.
- cmd_ready  in  1  read command accept.
- cmd_addr  out  ADDR_W  command address.
- cmd_len  out  LEN_W  command burst length.
- rsp_done  in  1  single-cycle pulse per completed burst.
- outstanding  out  CNT_W  accepted bursts not yet completed.
- busy  out  1  high when state is not IDLE or outstanding is not 0.
- err_underflow  out  1  sticky; set by rsp_done while outstanding is 0.
- cmd_count  out  32  total accepted commands; wraps at 2^32.

Behaviour:
- Reset values: state IDLE; fifo_rd_en=0; cmd_valid=0; cmd_addr=0; cmd_len=BURST_LEN; outstanding=0; busy=0; err_underflow=0; cmd_count=0.
- fifo_rd_en is combinational from state: asserted only in POP.
- State IDLE:
  - Go to POP when enable=1, flush=0, fifo_rd_empty=0 and outstanding < MAX_OUTSTANDING.
  - The outstanding value used is the registered value; a same-cycle rsp_done does not unlock a pop that cycle.
- State POP (1 cycle, fifo_rd_en=1): go to CAPTURE unconditionally.
- State CAPTURE:
  - Register cmd_addr = fifo_rd_data + ADDR_OFFSET, truncated to ADDR_W bits.
  - Set cmd_valid=1 and go to ISSUE.
- State ISSUE:
  - While cmd_ready=0, cmd_valid, cmd_addr and cmd_len are held stable.
  - When cmd_valid=1 and cmd_ready=1: the handshake completes, cmd_valid goes to 0 next cycle, cmd_count increments, outstanding increments, and the state returns to IDLE.
- Throughput: at most one command every 4 cycles (IDLE, POP, CAPTURE, ISSUE with cmd_ready=1).
- Latency: 3 cycles from the IDLE cycle that meets the pop conditions to the first cmd_valid=1 cycle.
- Outstanding counter:
  - Accept only: +1. rsp_done only: -1.
  - Accept and rsp_done in the same cycle: unchanged.
  - rsp_done while outstanding=0: counter holds at 0 and err_underflow is set; only rst_n clears it.
- Outstanding never exceeds MAX_OUTSTANDING, because a pop requires outstanding < MAX and only one address is in flight at a time.
- flush:
  - In IDLE: prevents the transition to POP.
  - In POP or CAPTURE: the sequence continues to ISSUE; a popped address is never dropped.
  - In ISSUE: cmd_valid is not withdrawn; the handshake completes normally.
  - flush never alters outstanding.
- enable=0 behaves like flush for the start of new pops only.
- fifo_rd_empty rising during POP or CAPTURE is ignored; the pop was already legal in IDLE.
- Asynchronous reset mid-operation: every register returns to its reset value immediately. A held command is dropped, and the upstream FIFO is expected to be reset in the same domain.

Decomposition:
- Shared package store_addr_pkg:
  - State encoding enum (IDLE, POP, CAPTURE, ISSUE).
  - Default constants ADDR_W, LEN_W and BURST_LEN, also used by the FIFO wrapper instantiation.
- One natural sub-module: store_addr_credit_cnt.
  - Saturating up/down outstanding counter with underflow flag and a below-limit output.

Test Plan:
- FIFO holds 3 addresses (0x010, 0x020, 0x3FF), ADDR_OFFSET=2, cmd_ready=1:
  - cmd_addr sequence 0x012, 0x022, 0x001 (wrap), cmd_len=16.
  - Commands spaced 4 cycles apart; cmd_count=3; outstanding=3.
- MAX_OUTSTANDING=4, no rsp_done, FIFO holds 6 addresses:
  - Exactly 4 commands issued; fifo_rd_en stays 0 afterwards.
  - One rsp_done pulse produces exactly 1 further pop and command.
- cmd_ready held low for 10 cycles during ISSUE:
  - cmd_valid and cmd_addr stay stable for all 10 cycles.
  - Accepted on cycle 11; outstanding +1.
- Accept and rsp_done in the same cycle with outstanding=2: outstanding stays 2.
- rsp_done with outstanding=0: err_underflow=1 and stays set; outstanding stays 0.
- flush asserted in the CAPTURE cycle:
  - The command still issues and completes.
  - No further pops occur while flush=1.
  - Assert rst_n=0 during a later ISSUE: cmd_valid=0 and all outputs at reset values immediately.
